// File: rtl/frame_sequencer.sv
// Frame sequencer: frames pixels into an upscaling core, pads short frames, discards overlong ones,
// and tracks the number of frames in flight between the core input and the upscaled output.
module frame_sequencer #(
  parameter int Height      = 600,
  parameter int Width       = 800,
  parameter int Scale       = 2,
  parameter int MaxInFlight = 2
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic                               source_valid_i,
  output logic                               source_ready_o,
  input  logic                               source_last_i,
  output logic                               core_valid_o,
  input  logic                               core_ready_i,
  output logic                               core_pad_o,
  input  logic                               core_out_valid_i,
  output logic                               core_out_ready_o,
  output logic                               sink_valid_o,
  input  logic                               sink_ready_i,
  output logic                               sink_last_o,
  output logic [$clog2(MaxInFlight+1)-1:0]   in_flight_o,
  output logic                               frame_error_o,
  output logic                               busy_o
);

  // state   | meaning
  // IDLE    | between frames; waits for enable_i and a free in-flight slot
  // STREAM  | pixels pass straight from source to core
  // PAD     | source ended early; zero pixels fill the rest of the frame
  // DISCARD | frame full but source kept going; drop until source_last_i

  localparam int IFW = $clog2(MaxInFlight + 1);
  localparam int CW  = (Width > 1) ? $clog2(Width) : 1;
  localparam int RW  = (Height > 1) ? $clog2(Height) : 1;
  localparam int OCW = (Width * Scale > 1) ? $clog2(Width * Scale) : 1;
  localparam int ORW = (Height * Scale > 1) ? $clog2(Height * Scale) : 1;

  localparam logic [IFW-1:0] IF_MAX    = IFW'(MaxInFlight);
  localparam logic [CW-1:0]  COL_LAST  = CW'(Width - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(Height - 1);
  localparam logic [OCW-1:0] OCOL_LAST = OCW'(Width * Scale - 1);
  localparam logic [ORW-1:0] OROW_LAST = ORW'(Height * Scale - 1);

  typedef enum logic [1:0] {IDLE, STREAM, PAD, DISCARD} state_t;

  state_t         state;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [OCW-1:0] ocol;
  logic [ORW-1:0] orow;

  logic in_xfer, in_final, frame_in;
  logic out_xfer, out_final, frame_out;

  always_comb begin
    source_ready_o = 1'b0;
    core_valid_o   = 1'b0;
    core_pad_o     = 1'b0;
    if (!reset_i) begin
      case (state)
        STREAM: begin
          core_valid_o   = source_valid_i;
          source_ready_o = core_ready_i;
        end
        PAD: begin
          core_valid_o = 1'b1;
          core_pad_o   = 1'b1;
        end
        DISCARD: source_ready_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign sink_valid_o     = core_out_valid_i;
  assign core_out_ready_o = sink_ready_i;

  assign in_xfer   = core_valid_o & core_ready_i;
  assign in_final  = (col == COL_LAST) && (row == ROW_LAST);
  assign frame_in  = in_xfer & in_final;
  assign out_xfer  = sink_valid_o & sink_ready_i;
  assign out_final = (ocol == OCOL_LAST) && (orow == OROW_LAST);
  // Guarding on a nonzero count keeps a stray output frame from wrapping the counter.
  assign frame_out = out_xfer & out_final & (in_flight_o != '0);

  assign sink_last_o = !reset_i && out_final;
  assign busy_o      = (state != IDLE) || (in_flight_o != '0);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state         <= IDLE;
      col           <= '0;
      row           <= '0;
      ocol          <= '0;
      orow          <= '0;
      in_flight_o   <= '0;
      frame_error_o <= 1'b0;
    end else begin
      if (frame_in && !frame_out)
        in_flight_o <= in_flight_o + 1'b1;
      else if (frame_out && !frame_in)
        in_flight_o <= in_flight_o - 1'b1;

      if (sink_valid_o && in_flight_o == '0)
        frame_error_o <= 1'b1;

      if (out_xfer) begin
        if (out_final) begin
          ocol <= '0;
          orow <= '0;
        end else if (ocol == OCOL_LAST) begin
          ocol <= '0;
          orow <= orow + 1'b1;
        end else begin
          ocol <= ocol + 1'b1;
        end
      end

      if (in_xfer) begin
        if (in_final) begin
          col <= '0;
          row <= '0;
        end else if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      case (state)
        IDLE:
          if (enable_i && in_flight_o < IF_MAX) state <= STREAM;
        STREAM:
          if (in_xfer) begin
            if (in_final) begin
              if (source_last_i) begin
                state <= IDLE;
              end else begin
                state         <= DISCARD;
                frame_error_o <= 1'b1;
              end
            end else if (source_last_i) begin
              state         <= PAD;
              frame_error_o <= 1'b1;
            end
          end
        PAD:
          if (frame_in) state <= IDLE;
        DISCARD:
          if (source_valid_i && source_last_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a 2x3 input frame upscaled by 2 (4x6 = 24 output beats).
module tb_frame_sequencer;

  localparam int H = 2;
  localparam int W = 3;
  localparam int S = 2;
  localparam int M = 2;
  localparam int OUT_BEATS = H * S * W * S;

  logic clk = 1'b0;
  logic reset_i, enable_i, source_valid_i, source_last_i, core_ready_i;
  logic core_out_valid_i, sink_ready_i;
  logic source_ready_o, core_valid_o, core_pad_o, core_out_ready_o;
  logic sink_valid_o, sink_last_o, frame_error_o, busy_o;
  logic [$clog2(M+1)-1:0] in_flight_o;

  int total = 0;
  int bad   = 0;
  int xfers = 0;

  always #5 clk = ~clk;

  frame_sequencer #(.Height(H), .Width(W), .Scale(S), .MaxInFlight(M)) dut (
    .clock_i          (clk),
    .reset_i          (reset_i),
    .enable_i         (enable_i),
    .source_valid_i   (source_valid_i),
    .source_ready_o   (source_ready_o),
    .source_last_i    (source_last_i),
    .core_valid_o     (core_valid_o),
    .core_ready_i     (core_ready_i),
    .core_pad_o       (core_pad_o),
    .core_out_valid_i (core_out_valid_i),
    .core_out_ready_o (core_out_ready_o),
    .sink_valid_o     (sink_valid_o),
    .sink_ready_i     (sink_ready_i),
    .sink_last_o      (sink_last_o),
    .in_flight_o      (in_flight_o),
    .frame_error_o    (frame_error_o),
    .busy_o           (busy_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic send_pixels(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      source_valid_i = 1'b1;
      source_last_i  = (i == last_at);
      #1;
      if (core_valid_o && core_ready_i) xfers++;
      tick();
    end
    source_valid_i = 1'b0;
    source_last_i  = 1'b0;
  endtask

  task automatic drain(input int n);
    core_out_valid_i = 1'b1;
    sink_ready_i     = 1'b0;
    #1;
    chk("out_ready_stall", int'(core_out_ready_o), 0);
    chk("sink_valid_pass", int'(sink_valid_o), 1);
    tick();
    sink_ready_i = 1'b1;
    for (int b = 0; b < n; b++) begin
      #1;
      chk("sink_last", int'(sink_last_o), (b == n - 1) ? 1 : 0);
      tick();
    end
    core_out_valid_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; enable_i = 1'b0; source_valid_i = 1'b0; source_last_i = 1'b0;
    core_ready_i = 1'b1; core_out_valid_i = 1'b1; sink_ready_i = 1'b1;
    tick(); tick();
    #1;
    chk("rst_sink_valid_pass", int'(sink_valid_o), 1);
    chk("rst_out_ready_pass", int'(core_out_ready_o), 1);
    chk("rst_sink_last", int'(sink_last_o), 0);
    chk("rst_source_ready", int'(source_ready_o), 0);
    chk("rst_core_valid", int'(core_valid_o), 0);
    core_out_valid_i = 1'b0;
    reset_i = 1'b0;
    tick();
    #1;
    chk("rst_in_flight", int'(in_flight_o), 0);
    chk("rst_error", int'(frame_error_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_pad", int'(core_pad_o), 0);

    // Clean frame, with one core backpressure cycle and enable dropped mid-frame
    enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
    source_valid_i = 1'b1; core_ready_i = 1'b0;
    #1;
    chk("bp_core_valid", int'(core_valid_o), 1);
    chk("bp_source_ready", int'(source_ready_o), 0);
    tick();
    core_ready_i = 1'b1;
    xfers = 0;
    send_pixels(6, 5);
    #1;
    chk("f1_xfers", xfers, 6);
    chk("f1_in_flight", int'(in_flight_o), 1);
    chk("f1_error", int'(frame_error_o), 0);
    chk("f1_idle_ready", int'(source_ready_o), 0);
    chk("f1_busy", int'(busy_o), 1);

    drain(OUT_BEATS);
    #1;
    chk("d1_in_flight", int'(in_flight_o), 0);
    chk("d1_busy", int'(busy_o), 0);
    chk("d1_error", int'(frame_error_o), 0);

    // Short frame: last on 4th pixel, two pad beats
    enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
    send_pixels(4, 3);
    #1;
    chk("short_error", int'(frame_error_o), 1);
    for (int p = 0; p < 2; p++) begin
      #1;
      chk("pad_flag", int'(core_pad_o), 1);
      chk("pad_valid", int'(core_valid_o), 1);
      chk("pad_source_ready", int'(source_ready_o), 0);
      tick();
    end
    #1;
    chk("pad_done_flag", int'(core_pad_o), 0);
    chk("pad_in_flight", int'(in_flight_o), 1);
    drain(OUT_BEATS);
    #1;
    chk("d2_in_flight", int'(in_flight_o), 0);

    // Long frame: six pixels without last, then three extras dropped
    enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
    send_pixels(6, -1);
    #1;
    chk("long_in_flight", int'(in_flight_o), 1);
    chk("long_error", int'(frame_error_o), 1);
    for (int i = 0; i < 3; i++) begin
      source_valid_i = 1'b1;
      source_last_i  = (i == 2);
      #1;
      chk("discard_core_valid", int'(core_valid_o), 0);
      chk("discard_source_ready", int'(source_ready_o), 1);
      tick();
    end
    source_valid_i = 1'b0; source_last_i = 1'b0;
    #1;
    chk("discard_idle_ready", int'(source_ready_o), 0);
    chk("discard_in_flight", int'(in_flight_o), 1);
    drain(OUT_BEATS);

    // Two frames in flight stall the third until one drains
    enable_i = 1'b1;
    tick();
    send_pixels(6, 5);
    tick();
    send_pixels(6, 5);
    #1;
    chk("full_in_flight", int'(in_flight_o), 2);
    source_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_stall_ready", int'(source_ready_o), 0);
      tick();
    end
    source_valid_i = 1'b0;
    drain(OUT_BEATS);
    #1;
    chk("unstall_in_flight", int'(in_flight_o), 1);
    tick();
    source_valid_i = 1'b1;
    #1;
    chk("unstall_ready", int'(source_ready_o), 1);
    tick();
    send_pixels(2, -1);

    // Reset mid-frame after the third pixel, with inputs still active
    reset_i = 1'b1; source_valid_i = 1'b1; source_last_i = 1'b1;
    tick();
    reset_i = 1'b0; source_valid_i = 1'b0; source_last_i = 1'b0; enable_i = 1'b0;
    #1;
    chk("mid_rst_in_flight", int'(in_flight_o), 0);
    chk("mid_rst_error", int'(frame_error_o), 0);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_ready", int'(source_ready_o), 0);
    chk("mid_rst_core_valid", int'(core_valid_o), 0);
    chk("mid_rst_pad", int'(core_pad_o), 0);
    enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
    xfers = 0;
    send_pixels(6, 5);
    #1;
    chk("post_rst_xfers", xfers, 6);
    chk("post_rst_in_flight", int'(in_flight_o), 1);
    chk("post_rst_error", int'(frame_error_o), 0);
    drain(OUT_BEATS);
    #1;
    chk("post_rst_drained", int'(in_flight_o), 0);
    chk("post_rst_busy", int'(busy_o), 0);

    // Output beat with nothing in flight flags an error but still passes through
    core_out_valid_i = 1'b1; sink_ready_i = 1'b0;
    #1;
    chk("orphan_pass", int'(sink_valid_o), 1);
    tick();
    core_out_valid_i = 1'b0;
    #1;
    chk("orphan_error", int'(frame_error_o), 1);
    chk("orphan_in_flight", int'(in_flight_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
